sram_like_bus_arbiter: RTL and testbench
========================================

// Module: sram_like_bus_arbiter
// PURPOSE
//  Shares one downstream sram-like port between the instruction and data sram-like masters.
//  Sits after i_sram_to_sram_like/d_sram_to_sram_like and before the MMU/bridge.
//  Grants data by default, locks the grant until addr_ok, and tracks in-flight owners in order.
//  Caps data priority with a starvation counter so inst fetch always makes progress.
// PARAMETERS
//  ADDR_W           32  address width
//  DATA_W           32  data width
//  MAX_OUTSTANDING  2   accepted-but-unanswered transactions allowed (>=1)
//  STARVE_LIMIT     8   cycles inst may wait before it overrides data priority (>=1)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous, active-low reset (0 = reset)
//  inst_req      in   1       inst read request; held until inst_addr_ok
//  inst_addr     in   ADDR_W  inst virtual address; forwarded with size 2'b10, wr=0
//  inst_addr_ok  out  1       inst request accepted downstream
//  inst_data_ok  out  1       inst read data valid
//  inst_rdata    out  DATA_W  = mem_rdata
//  data_req      in   1       data request; held until data_addr_ok
//  data_wr       in   1       1 = write
//  data_size     in   2       0 byte, 1 half, 2 word
//  data_addr     in   ADDR_W  data virtual address
//  data_wdata    in   DATA_W  write data
//  data_addr_ok  out  1       data request accepted downstream
//  data_data_ok  out  1       data read/write completion
//  data_rdata    out  DATA_W  = mem_rdata
//  mem_req       out  1       downstream request
//  mem_wr        out  1       downstream write
//  mem_size      out  2       downstream size
//  mem_addr      out  ADDR_W  downstream address
//  mem_wdata     out  DATA_W  downstream write data
//  mem_addr_ok   in   1       downstream accept
//  mem_data_ok   in   1       downstream completion, strictly in acceptance order
//  mem_rdata     in   DATA_W  downstream read data
//  proto_err     out  1       sticky: mem_data_ok seen with no transaction outstanding
// BEHAVIOUR
//  Reset (rst=0 at posedge): owner FIFO empty, lock clear, starve_cnt=0, proto_err=0.
//    Resetting mid-transfer drops all in-flight state; downstream is reset alongside.
//  Grant, combinational:
//    lock_valid -> lock_id.
//    Else starve_cnt>=STARVE_LIMIT && inst_req -> INST.
//    Else data_req -> DATA; else inst_req -> INST; else none.
//  mem_req = granted req && (count<MAX_OUTSTANDING). No bypass when full, even if data_ok pops that cycle.
//  mem_wr/size/addr/wdata mux from the grantee. Idle outputs are 0.
//  mem_addr_ok routes only to the grantee's *_addr_ok, and only while mem_req=1.
//  Lock: mem_req && !mem_addr_ok -> lock_valid=1, lock_id=grantee. Cleared on the cycle mem_addr_ok=1.
//  Accept (mem_req && mem_addr_ok): push grantee ID into the owner FIFO.
//  Completion (mem_data_ok): pop head; pulse head owner's *_data_ok in the same cycle (0 latency).
//  Push and pop in the same cycle: count unchanged, both take effect.
//  mem_data_ok with count==0: no pop, no *_data_ok, proto_err<=1 (held until reset).
//  starve_cnt (width clog2(STARVE_LIMIT+1), saturating):
//    +1 each cycle inst_req=1 and inst not accepted.
//    Cleared on inst accept or inst_req=0.
//  Throughput: 1 accept/cycle. Latency req->mem_req is 0 cycles when not full.
// STRUCTURE
//  Package mips_bus_pkg: OWN_INST=1'b0, OWN_DATA=1'b1; SIZE_BYTE/HALF/WORD = 2'd0/1/2.
//  Sub-module owner_fifo: 1-bit-wide, MAX_OUTSTANDING-deep circular FIFO.
//    Pointer wrap; outputs head, count, full, empty.
//  Top level holds the grant mux, lock register, starve counter and proto_err.
// TESTING
//  1. inst_req=data_req=1 from idle, mem_addr_ok=1
//     -> cycle0 mem_addr=data_addr, data_addr_ok=1; cycle1 mem_addr=inst_addr, inst_addr_ok=1.
//  2. data_req=1, mem_addr_ok=0 for 3 cycles, inst_req rises in cycle1
//     -> grant stays DATA until addr_ok, inst accepted the next cycle.
//  3. MAX_OUTSTANDING=2, accept data then inst, no mem_data_ok
//     -> cycle2 mem_req=0; two mem_data_ok pulses -> data_data_ok then inst_data_ok.
//  4. data_req and inst_req held, mem_addr_ok=1, instant mem_data_ok
//     -> inst accepted in cycle 8 (STARVE_LIMIT=8), starve_cnt returns to 0.
//  5. mem_data_ok=1 with empty FIFO -> proto_err=1 next cycle, no *_data_ok, stays 1 until rst=0.
//  6. rst=0 for one cycle with 1 outstanding and lock set
//     -> count=0, lock clear, proto_err=0; the next request is arbitrated fresh.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: owner IDs and transfer sizes shared by the sram-like bus blocks
package mips_bus_pkg;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: 1-bit-wide circular FIFO recording which master owns each in-flight transfer
module owner_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sram_like_bus_arbiter.sv
// sram_like_bus_arbiter: shares one sram-like port between inst and data masters,
// data-first with a starvation cap, grant locked until addr_ok, owners tracked in order.
module sram_like_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic lock_valid, lock_id, gnt_id, gnt_data, pop, head, full, empty;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  always_comb begin
    gnt_id = lock_valid ? lock_id :
             (starve_cnt >= SW'(STARVE_LIMIT) && inst_req) ? OWN_INST :
             data_req ? OWN_DATA : OWN_INST;
    mem_req = (gnt_id == OWN_DATA ? data_req : inst_req) && !full;
    gnt_data = mem_req && gnt_id == OWN_DATA;
    mem_wr = gnt_data && data_wr;
    mem_size = !mem_req ? SIZE_BYTE : gnt_data ? data_size : SIZE_WORD;
    mem_addr = !mem_req ? '0 : gnt_data ? data_addr : inst_addr;
    mem_wdata = gnt_data ? data_wdata : '0;
    inst_addr_ok = mem_req && mem_addr_ok && gnt_id == OWN_INST;
    data_addr_ok = gnt_data && mem_addr_ok;
    pop = mem_data_ok && !empty;
    inst_data_ok = pop && head == OWN_INST;
    data_data_ok = pop && head == OWN_DATA;
  end
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk(clk), .rst(rst), .push(mem_req && mem_addr_ok), .pop(pop), .din(gnt_id),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_valid <= 1'b0;
      lock_id <= OWN_INST;
      starve_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      if (mem_req) lock_valid <= !mem_addr_ok;
      if (mem_req && !mem_addr_ok) lock_id <= gnt_id;
      starve_cnt <= !(inst_req && !inst_addr_ok) ? '0 :
                    (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
      proto_err <= proto_err | (mem_data_ok && count == '0);
    end
  end
endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// tb_sram_like_bus_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_sram_like_bus_arbiter;
  localparam int MAXO = 2;
  localparam int LIM = 8;
  logic clk, rst;
  logic inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, proto_err;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int total = 0, bad = 0;
  bit oq[$];
  bit lk_v, lk_id, perr;
  int st;
  bit e_g, e_req, e_iaok, e_daok, e_pop;

  sram_like_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current inputs, derived from the priority rules and owner queue
  task automatic chk();
    bit gv;
    #1;
    gv = 1;
    if (lk_v) e_g = lk_id;
    else if (st >= LIM && inst_req) e_g = 0;
    else if (data_req) e_g = 1;
    else if (inst_req) e_g = 0;
    else gv = 0;
    e_req = gv && (e_g ? data_req : inst_req) && oq.size() < MAXO;
    e_iaok = e_req && !e_g && mem_addr_ok;
    e_daok = e_req && e_g && mem_addr_ok;
    e_pop = mem_data_ok && oq.size() > 0;
    check("mem_req", mem_req, e_req);
    check("mem_addr", mem_addr, !e_req ? 32'h0 : e_g ? data_addr : inst_addr);
    check("mem_wr", mem_wr, e_req && e_g && data_wr);
    check("mem_size", mem_size, !e_req ? 2'd0 : e_g ? data_size : 2'd2);
    check("mem_wdata", mem_wdata, (e_req && e_g) ? data_wdata : 32'h0);
    check("inst_addr_ok", inst_addr_ok, e_iaok);
    check("data_addr_ok", data_addr_ok, e_daok);
    check("inst_data_ok", inst_data_ok, e_pop && oq[0] == 0);
    check("data_data_ok", data_data_ok, e_pop && oq[0] == 1);
    check("inst_rdata", inst_rdata, mem_rdata);
    check("data_rdata", data_rdata, mem_rdata);
    check("proto_err", proto_err, perr);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst) begin
      oq.delete();
      lk_v = 0;
      st = 0;
      perr = 0;
    end else begin
      if (e_req) begin
        lk_v = !mem_addr_ok;
        lk_id = e_g;
      end
      if (mem_data_ok && oq.size() == 0) perr = 1;
      if (e_pop) void'(oq.pop_front());
      if (e_req && mem_addr_ok) oq.push_back(e_g);
      st = (inst_req && !e_iaok) ? (st < LIM ? st + 1 : LIM) : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic drain();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 8 && oq.size() > 0; i++) begin
      mem_data_ok = 1;
      mem_rdata = $urandom;
      chk();
      adv();
    end
    mem_data_ok = 0;
  endtask

  initial begin
    bit ip, dp;
    rst = 0;
    idle_in();
    repeat (2) @(negedge clk);
    oq.delete(); lk_v = 0; st = 0; perr = 0;
    rst = 1;
    chk();
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_proto_err", proto_err, 1'b0);
    adv();
    // both request from idle: data first, inst next
    inst_req = 1; inst_addr = 32'h2000; data_req = 1; data_addr = 32'h1000; mem_addr_ok = 1;
    chk();
    check("t1_c0_addr", mem_addr, 32'h1000);
    check("t1_c0_daok", data_addr_ok, 1'b1);
    adv();
    data_req = 0;
    chk();
    check("t1_c1_addr", mem_addr, 32'h2000);
    check("t1_c1_iaok", inst_addr_ok, 1'b1);
    adv();
    drain();
    // grant locked on data while addr_ok is low
    data_req = 1; data_addr = 32'h3000; mem_addr_ok = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin inst_req = 1; inst_addr = 32'h4000; end
      mem_addr_ok = (c == 3);
      chk();
      check("t2_lock_addr", mem_addr, 32'h3000);
      adv();
    end
    data_req = 0; mem_addr_ok = 1;
    chk();
    check("t2_inst_next", inst_addr_ok, 1'b1);
    adv();
    drain();
    // fill to MAX_OUTSTANDING, then in-order completions
    data_req = 1; data_addr = 32'h10; inst_req = 1; inst_addr = 32'h20; mem_addr_ok = 1;
    chk(); adv();
    data_req = 0;
    chk(); adv();
    data_req = 1; inst_req = 0;
    chk();
    check("t3_full_noreq", mem_req, 1'b0);
    adv();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    chk();
    check("t3_first_dok", data_data_ok, 1'b1);
    adv();
    chk();
    check("t3_second_iok", inst_data_ok, 1'b1);
    adv();
    mem_data_ok = 0;
    drain();
    // starvation cap
    for (int k = 0; k < 10; k++) begin
      data_req = 1; data_addr = 32'h100 + k; inst_req = 1; inst_addr = 32'h200 + k;
      mem_addr_ok = 1; mem_data_ok = oq.size() > 0;
      chk();
      if (k < 8 || k == 9) check("t4_data_acc", data_addr_ok, 1'b1);
      else check("t4_inst_acc8", inst_addr_ok, 1'b1);
      adv();
    end
    drain();
    // completion with nothing outstanding
    mem_data_ok = 1;
    chk();
    check("t5_no_iok", inst_data_ok, 1'b0);
    check("t5_no_dok", data_data_ok, 1'b0);
    adv();
    mem_data_ok = 0;
    for (int k = 0; k < 3; k++) begin
      chk();
      check("t5_sticky", proto_err, 1'b1);
      adv();
    end
    // reset with one outstanding and a lock held
    data_req = 1; data_addr = 32'h600; mem_addr_ok = 1;
    chk(); adv();
    mem_addr_ok = 0;
    chk(); adv();
    rst = 0; idle_in();
    chk(); adv();
    rst = 1;
    chk();
    check("t6_perr_clr", proto_err, 1'b0);
    adv();
    inst_req = 1; inst_addr = 32'h5000; mem_data_ok = 1;
    chk();
    check("t6_fresh_addr", mem_addr, 32'h5000);
    check("t6_no_dok", data_data_ok, 1'b0);
    adv();
    rst = 0; idle_in();
    adv();
    rst = 1;
    // randomized traffic obeying the hold-until-addr_ok protocol
    ip = 0; dp = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip) begin inst_req = $urandom_range(0, 1); inst_addr = $urandom; ip = inst_req; end
      if (!dp) begin
        data_req = $urandom_range(0, 9) < 7; data_addr = $urandom; data_wr = $urandom_range(0, 1);
        data_size = 2'($urandom_range(0, 2)); data_wdata = $urandom; dp = data_req;
      end
      mem_addr_ok = $urandom_range(0, 9) < 6;
      mem_data_ok = oq.size() > 0 && $urandom_range(0, 9) < 4;
      mem_rdata = $urandom;
      chk();
      if (e_iaok) ip = 0;
      if (e_daok) dp = 0;
      adv();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
